// File: rtl/fish_uart_pkg.sv
// Shared UART definitions for the fish_tank serial path (receiver state
// encoding, bit-period helper, parity sense constants shared with uart_tx).
package fish_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PARITY_SENSE_EVEN = 1'b0;
  localparam logic PARITY_SENSE_ODD  = 1'b1;

  // Integer-truncated number of system clocks per serial bit.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Ready/valid byte port between the UART receiver (master) and its
// consumer (slave).
interface uart_rx_frame_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/bit_sync.sv
// N-flop synchronizer for an asynchronous single-bit input; every stage
// presets to 1 so an idle-high line looks idle straight out of reset.
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[N-2:0], d};
    end
  end

  assign q = sync_reg[N-1];

endmodule

// File: rtl/uart_rx_frame.sv
// Byte-wide UART receiver (8-N-1 or 8-E/O-1) with start/parity/stop checks
// and a ready/valid output register that holds a byte until accepted.
module uart_rx_frame
  import fish_uart_pkg::*;
#(
  parameter int   CLK_FREQ   = 50_000_000,
  parameter int   BAUD       = 115200,
  parameter logic PARITY_EN  = 1'b0,
  parameter logic PARITY_ODD = PARITY_SENSE_EVEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uart_rx,
  uart_rx_frame_if.master rx,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun,
  output logic            busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

  logic             rx_s;
  logic             rx_prev_reg;
  rx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             par_bad_reg, par_bad_next;
  logic             good_reg, good_next;
  logic             frame_err_reg, frame_err_next;
  logic             parity_err_reg, parity_err_next;
  logic             overrun_reg;
  logic [7:0]       data_reg;
  logic             valid_reg;

  bit_sync #(.N(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (uart_rx),
    .q     (rx_s)
  );

  // Counter runs start-edge -> mid-start, then mid-bit to mid-bit.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg + CNT_W'(1);
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    par_bad_next    = par_bad_reg;
    good_next       = 1'b0;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (rx_prev_reg && !rx_s) begin
          state_next   = START;
          bit_idx_next = 3'd0;
          par_bad_next = 1'b0;
        end
      end
      START: begin
        if (cnt_reg == CNT_MID) begin
          cnt_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift_reg[7:1]};
          bit_idx_next = bit_idx_reg + 3'd1;
          if (bit_idx_reg == 3'd7) begin
            state_next = PARITY_EN ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next     = '0;
          par_bad_next = (rx_s != (^shift_reg ^ PARITY_ODD));
          state_next   = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (!rx_s) begin
            frame_err_next = 1'b1;
          end else if (par_bad_reg) begin
            parity_err_next = 1'b1;
          end else begin
            good_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= 3'd0;
      shift_reg      <= 8'h00;
      par_bad_reg    <= 1'b0;
      good_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
      rx_prev_reg    <= 1'b1;
      data_reg       <= 8'h00;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      par_bad_reg    <= par_bad_next;
      good_reg       <= good_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
      rx_prev_reg    <= rx_s;
      overrun_reg    <= good_reg && valid_reg && !rx.rx_ready;
      // A finished byte may replace the held one only when it is being accepted.
      if (good_reg && (!valid_reg || rx.rx_ready)) begin
        data_reg  <= shift_reg;
        valid_reg <= 1'b1;
      end else if (valid_reg && rx.rx_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign rx.rx_data  = data_reg;
  assign rx.rx_valid = valid_reg;
  assign frame_err   = frame_err_reg;
  assign parity_err  = parity_err_reg;
  assign overrun     = overrun_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8-N-1 instance and an 8-E-1 instance
// checked every cycle against a frame-level expectation queue.
module tb_uart_rx_frame;

  localparam int CPB      = 50_000_000 / 115200;
  localparam int K_GOOD   = 0;
  localparam int K_FRAME  = 1;
  localparam int K_PARITY = 2;

  typedef struct {
    int         id;
    int         kind;
    logic [7:0] data;
    longint     due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic line0 = 1'b1;
  logic line1 = 1'b1;
  logic [1:0] rdy = 2'b11;
  logic fe0, pe0, ov0, busy0, fe1, pe1, ov1, busy1;

  uart_rx_frame_if if0();
  uart_rx_frame_if if1();

  assign if0.rx_ready = rdy[0];
  assign if1.rx_ready = rdy[1];

  uart_rx_frame dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (line0),
    .rx         (if0),
    .frame_err  (fe0),
    .parity_err (pe0),
    .overrun    (ov0),
    .busy       (busy0)
  );

  uart_rx_frame #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (line1),
    .rx         (if1),
    .frame_err  (fe1),
    .parity_err (pe1),
    .overrun    (ov1),
    .busy       (busy1)
  );

  always #5 clk = ~clk;

  logic [1:0] o_v, o_fe, o_pe, o_ov, o_busy;
  logic [7:0] o_d [2];
  assign o_v    = {if1.rx_valid, if0.rx_valid};
  assign o_fe   = {fe1, fe0};
  assign o_pe   = {pe1, pe0};
  assign o_ov   = {ov1, ov0};
  assign o_busy = {busy1, busy0};
  assign o_d[0] = if0.rx_data;
  assign o_d[1] = if1.rx_data;

  // Values the DUT saw at the most recent rising edge.
  longint     cyc = 0;
  logic [1:0] rdy_edge = 2'b11;
  logic       rst_edge = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdy_edge <= rdy;
    rst_edge <= !rst_n;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  exp_t       q[$];
  bit         chk_en = 1'b0;
  logic [1:0] m_valid = 2'b00;
  logic [7:0] m_data [2] = '{8'h00, 8'h00};
  int         fe_cnt [2] = '{0, 0};
  int         pe_cnt [2] = '{0, 0};
  int         ov_cnt [2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin : per_dut
        bit     head_here, ld, any_ev, exp_ov, loaded;
        longint due;
        logic [3:0] ev;
        loaded = 1'b0;
        if (rst_edge) begin
          m_valid[i] = 1'b0;
          m_data[i]  = 8'h00;
          check({o_fe[i], o_pe[i], o_ov[i], o_busy[i]} == 4'b0000, "reset_flags_busy",
                {o_fe[i], o_pe[i], o_ov[i], o_busy[i]}, 0);
        end
        fe_cnt[i] += int'(o_fe[i]);
        pe_cnt[i] += int'(o_pe[i]);
        ov_cnt[i] += int'(o_ov[i]);
        head_here = (q.size() > 0) && (q[0].id == i);
        ld        = o_v[i] && (!m_valid[i] || rdy_edge[i]);
        ev        = {ld, o_ov[i], o_fe[i], o_pe[i]};
        any_ev    = (ev != 4'b0000);
        if (!head_here) begin
          check(!any_ev, "no_unexpected_event", ev, 0);
        end else if (any_ev) begin
          // Flags show one cycle before a byte would reach the output register.
          due = (q[0].kind == K_GOOD) ? q[0].due : q[0].due - 1;
          check((cyc >= due - 1) && (cyc <= due + 1), "event_timing", cyc, due);
          case (q[0].kind)
            K_GOOD: begin
              exp_ov = m_valid[i] && !rdy_edge[i];
              check(ev == (exp_ov ? 4'b0100 : 4'b1000), "good_frame_outcome", ev,
                    exp_ov ? 4'b0100 : 4'b1000);
              if (!exp_ov) begin
                m_valid[i] = 1'b1;
                m_data[i]  = q[0].data;
                loaded     = 1'b1;
              end
            end
            K_FRAME:  check(ev == 4'b0010, "frame_err_outcome", ev, 4'b0010);
            default:  check(ev == 4'b0001, "parity_err_outcome", ev, 4'b0001);
          endcase
          void'(q.pop_front());
        end else if (cyc > q[0].due + 1) begin
          vectors++;
          miscompares++;
          $display("FAIL frame_timeout: dut%0d byte %0h kind %0d got no event, required by cycle %0d",
                   i, q[0].data, q[0].kind, q[0].due + 1);
          void'(q.pop_front());
        end
        if (!loaded && m_valid[i] && rdy_edge[i]) m_valid[i] = 1'b0;
        check(o_v[i] == m_valid[i], "rx_valid", o_v[i], m_valid[i]);
        if (m_valid[i]) check(o_d[i] == m_data[i], "rx_data", o_d[i], m_data[i]);
      end
    end
  end

  task automatic drive_bit(input int id, input logic v);
    if (id == 0) line0 = v;
    else         line1 = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame (call at a falling clock edge) and queues its outcome.
  task automatic send_frame(input int id, input logic [7:0] b, input logic par, input logic stop);
    exp_t e;
    int   pe;
    pe     = (id == 1) ? 1 : 0;
    e.id   = id;
    e.data = b;
    // First clock edge after the fall, then 2 sync + (9.5 + parity) bits + 1.
    e.due  = cyc + 4 + longint'(((19 + 2 * pe) * CPB) / 2);
    if (!stop)                           e.kind = K_FRAME;
    else if (pe == 1 && (par != ^b))     e.kind = K_PARITY;
    else                                 e.kind = K_GOOD;
    q.push_back(e);
    drive_bit(id, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(id, b[k]);
    if (pe == 1) drive_bit(id, par);
    drive_bit(id, stop);
    if (id == 0) line0 = 1'b1;
    else         line1 = 1'b1;
  endtask

  initial begin
    longint t0, lat;
    int     nbusy, base_fe, base_pe, base_ov;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check(if0.rx_data == 8'h00 && if1.rx_data == 8'h00, "reset_rx_data", {if1.rx_data, if0.rx_data}, 0);
    check(if0.rx_valid == 1'b0 && if1.rx_valid == 1'b0, "reset_rx_valid", {if1.rx_valid, if0.rx_valid}, 0);
    check({fe0, pe0, ov0, busy0} == 4'b0000, "reset_outputs", {fe0, pe0, ov0, busy0}, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    repeat (10) @(negedge clk);

    // 1: two back-to-back 8-N-1 bytes.
    t0 = cyc;
    lat = 0;
    fork
      begin
        send_frame(0, 8'h55, 1'b0, 1'b1);
        send_frame(0, 8'hA3, 1'b0, 1'b1);
      end
      begin
        for (int n = 0; n < 6000 && !if0.rx_valid; n++) @(negedge clk);
        lat = cyc - t0;
        check(lat >= 4125 && lat <= 4127, "t1_first_latency", lat, 4126);
        check(if0.rx_data == 8'h55, "t1_first_byte", if0.rx_data, 8'h55);
      end
    join
    repeat (20) @(negedge clk);
    check(if0.rx_data == 8'hA3, "t1_second_byte", if0.rx_data, 8'hA3);

    // 2: 100-clock glitch is rejected at the mid-start sample.
    nbusy = 0;
    fork
      begin
        line0 = 1'b0;
        repeat (100) @(negedge clk);
        line0 = 1'b1;
      end
      for (int n = 0; n < 600; n++) begin
        @(negedge clk);
        if (busy0) nbusy++;
      end
    join
    check(nbusy >= 216 && nbusy <= 218, "t2_glitch_busy_cycles", nbusy, 217);

    // 3: stop bit low, then a good byte.
    base_fe = fe_cnt[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check(fe_cnt[0] - base_fe == 1, "t3_frame_err_pulses", fe_cnt[0] - base_fe, 1);
    check(if0.rx_data == 8'hA3, "t3_bad_byte_dropped", if0.rx_data, 8'hA3);
    send_frame(0, 8'h81, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check(if0.rx_data == 8'h81, "t3_next_byte", if0.rx_data, 8'h81);

    // 4: even parity on the second instance; bad parity, then bad stop + bad parity.
    base_pe = pe_cnt[1];
    base_fe = fe_cnt[1];
    send_frame(1, 8'hA5, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check(if1.rx_data == 8'hA5, "t4_parity_good_byte", if1.rx_data, 8'hA5);
    send_frame(1, 8'hA5, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check(pe_cnt[1] - base_pe == 1, "t4_parity_err_pulses", pe_cnt[1] - base_pe, 1);
    send_frame(1, 8'hA5, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check(fe_cnt[1] - base_fe == 1, "t4_frame_err_priority", fe_cnt[1] - base_fe, 1);
    check(pe_cnt[1] - base_pe == 1, "t4_no_parity_with_frame", pe_cnt[1] - base_pe, 1);

    // 5: consumer stalled, second byte overruns.
    rdy[0]  = 1'b0;
    base_ov = ov_cnt[0];
    send_frame(0, 8'h12, 1'b0, 1'b1);
    send_frame(0, 8'h34, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check(if0.rx_valid == 1'b1, "t5_valid_held", if0.rx_valid, 1);
    check(if0.rx_data == 8'h12, "t5_old_byte_kept", if0.rx_data, 8'h12);
    check(ov_cnt[0] - base_ov == 1, "t5_overrun_pulses", ov_cnt[0] - base_ov, 1);
    rdy[0] = 1'b1;
    @(negedge clk);
    check(if0.rx_valid == 1'b0, "t5_valid_after_accept", if0.rx_valid, 0);
    repeat (10) @(negedge clk);

    // 6: reset pulse during D4 of 0xF0 (line high from D4 on), then 0xF0 intact.
    line0 = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    line0 = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check(busy0 == 1'b1, "t6_busy_before_reset", busy0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check({if0.rx_valid, busy0, fe0, pe0, ov0} == 5'b00000, "t6_outputs_after_reset",
          {if0.rx_valid, busy0, fe0, pe0, ov0}, 0);
    check(if0.rx_data == 8'h00, "t6_rx_data_after_reset", if0.rx_data, 0);
    repeat (5 * CPB) @(negedge clk);
    send_frame(0, 8'hF0, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check(if0.rx_data == 8'hF0, "t6_byte_after_reset", if0.rx_data, 8'hF0);

    for (int n = 0; n < 6000 && q.size() > 0; n++) @(negedge clk);
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_frames: %0d frames still expected, required 0", q.size());
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
